// File: rtl/mdu.sv
// Multiply/divide unit: MULT/MULTU/DIV/DIVU results land in HI/LO after a fixed
// MULT_CYCLES/DIV_CYCLES of Busy. Requests are dropped while Busy, so the core must stall.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdop_t;

  mdop_t       op;
  logic        accept;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] pend_hi, pend_lo, pend_hi_n, pend_lo_n;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo_s, rem_s, b_divu, quo_u, rem_u;
  logic        dz;

  assign op     = mdop_t'(MDOp);
  assign accept = Start && !Busy;
  assign dz     = (B == 32'd0);

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes; this also makes 0x80000000 / -1 come out as 0x80000000 rem 0.
  assign a_mag  = A[31] ? -A : A;
  assign b_mag  = B[31] ? -B : B;
  assign b_div  = dz ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_div;
  assign r_mag  = a_mag % b_div;
  assign quo_s  = (A[31] ^ B[31]) ? -q_mag : q_mag;
  assign rem_s  = A[31] ? -r_mag : r_mag;
  assign b_divu = dz ? 32'd1 : B;
  assign quo_u  = A / b_divu;
  assign rem_u  = A % b_divu;

  always_comb begin
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    cnt_n     = cnt;
    if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else if (accept) begin
      case (op)
        OP_MULT: begin
          {pend_hi_n, pend_lo_n} = prod_s;
          cnt_n = CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {pend_hi_n, pend_lo_n} = prod_u;
          cnt_n = CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          // HI/LO cannot change while busy, so a zero divisor simply re-commits them.
          pend_hi_n = dz ? HI : rem_s;
          pend_lo_n = dz ? LO : quo_s;
          cnt_n     = CW'(DIV_CYCLES);
        end
        OP_DIVU: begin
          pend_hi_n = dz ? HI : rem_u;
          pend_lo_n = dz ? LO : quo_u;
          cnt_n     = CW'(DIV_CYCLES);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      cnt     <= cnt_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      Busy    <= (cnt_n != '0);
      Done    <= (cnt == CW'(1));
      if (cnt == CW'(1)) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end else if (accept && op == OP_MTHI) begin
        HI <= A;
      end else if (accept && op == OP_MTLO) begin
        LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table, hand-written corner sequences, and
// randomized ops checked against a plain-arithmetic HI/LO model.
module tb_mdu;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_hi, model_lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
  endtask

  // Presents a request at a falling edge and drops Start just after the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    drive(op, a, b);
    @(posedge CLK);
    #1 Start = 1'b0;
  endtask

  // Counts falling edges that see Busy=1; returns at the first one with Busy=0 (bounded).
  task automatic wait_complete(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!Busy) break;
      n++;
    end
  endtask

  function automatic bit is_md(input logic [2:0] op);
    return op >= 3'd1 && op <= 3'd4;
  endfunction

  function automatic int lat(input logic [2:0] op);
    return (op <= 3'd2) ? 5 : 10;
  endfunction

  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      3'd3: if (b != 0) begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
      3'd4: if (b != 0) begin lo = a / b; hi = a % b; end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endfunction

  task automatic apply(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(op, a, b);
    if (is_md(op)) begin
      wait_complete(n);
      check({name, " busy_cycles"}, 64'(n), 64'(lat(op)));
      check({name, " done"}, 64'(Done), 64'd1);
    end else begin
      @(negedge CLK);
      check({name, " busy"}, 64'(Busy), 64'd0);
      check({name, " done"}, 64'(Done), 64'd0);
    end
    check({name, " hi"}, 64'(HI), 64'(ehi));
    check({name, " lo"}, 64'(LO), 64'(elo));
    @(negedge CLK);
    check({name, " done_drop"}, 64'(Done), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int n;
    bit seen;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs = '{
      '{"mult_neg",   3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA},
      '{"multu",      3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA},
      '{"div_neg",    3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
      '{"divu",       3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003},
      '{"mthi",       3'd5, 32'h11111111, 32'd0,        32'h11111111, 32'h00000003},
      '{"mtlo",       3'd6, 32'h22222222, 32'd0,        32'h11111111, 32'h22222222},
      '{"div_by0",    3'd3, 32'd1234,     32'd0,        32'h11111111, 32'h22222222},
      '{"div_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{"divu_by0",   3'd4, 32'd5,        32'd0,        32'h00000000, 32'h80000000},
      '{"nop",        3'd0, 32'h55555555, 32'd9,        32'h00000000, 32'h80000000},
      '{"rsvd",       3'd7, 32'h66666666, 32'd9,        32'h00000000, 32'h80000000},
      '{"multu_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{"mult_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
      '{"div_negdiv", 3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD}
    };

    Reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    Reset = 1'b0;

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Requests during a MULT (MTLO, then DIVU) must be dropped.
    issue(3'd1, 32'd3, 32'd4);
    @(negedge CLK);
    drive(3'd6, 32'hDEADBEEF, 32'd0);
    @(posedge CLK);
    #1 Start = 1'b0;
    @(negedge CLK);
    drive(3'd4, 32'd100, 32'd7);
    @(posedge CLK);
    #1 Start = 1'b0;
    wait_complete(n);
    check("rej busy_cycles", 64'(n + 2), 64'd5);
    check("rej done", 64'(Done), 64'd1);
    check("rej hi", 64'(HI), 64'd0);
    check("rej lo", 64'(LO), 64'd12);
    @(negedge CLK);
    check("rej no_divu", 64'(Busy), 64'd0);

    // Start on the completion edge is ignored; held one more cycle it is accepted.
    issue(3'd1, 32'd6, 32'd7);
    repeat (4) @(negedge CLK);
    @(negedge CLK);
    check("cedge busy5", 64'(Busy), 64'd1);
    drive(3'd4, 32'd7, 32'd2);
    @(posedge CLK);
    @(negedge CLK);
    check("cedge idle", 64'(Busy), 64'd0);
    check("cedge done", 64'(Done), 64'd1);
    check("cedge lo", 64'(LO), 64'd42);
    @(posedge CLK);
    #1 Start = 1'b0;
    wait_complete(n);
    check("retry busy_cycles", 64'(n), 64'd10);
    check("retry hi", 64'(HI), 64'd1);
    check("retry lo", 64'(LO), 64'd3);

    // MTHI then MULTU in the very next cycle.
    issue(3'd5, 32'hCAFEF00D, 32'd0);
    @(negedge CLK);
    check("b2b mthi", 64'(HI), 64'hCAFEF00D);
    check("b2b busy", 64'(Busy), 64'd0);
    drive(3'd2, 32'h00010000, 32'h00030000);
    @(posedge CLK);
    #1 Start = 1'b0;
    wait_complete(n);
    check("b2b busy_cycles", 64'(n), 64'd5);
    check("b2b hi", 64'(HI), 64'd3);
    check("b2b lo", 64'(LO), 64'd0);

    model_hi = 32'd3;
    model_lo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
      ref_op(rop, ra, rb, model_hi, model_lo);
      apply($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, model_hi, model_lo);
    end

    // Asynchronous reset in the middle of a MULT.
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0);
    @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    check("amid hi", 64'(HI), 64'd0);
    check("amid lo", 64'(LO), 64'd0);
    check("amid busy", 64'(Busy), 64'd0);
    #3 Reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (Done || Busy) seen = 1'b1;
    end
    check("amid no_done", 64'(seen), 64'd0);
    check("amid hi_after", 64'(HI), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
